// File: rtl/mux_stream_arbiter_pkg.sv
// ============================================================================
// Module   : mux_stream_arbiter_pkg
// Brief    : Shared widths, arbiter state encoding and grant-pick helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_stream_arbiter_pkg;

    localparam int DATA_BITS = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    // Grant choice from the request pair; ptr breaks ties (0 favours in0).
    function automatic arb_state_e arb_pick(input logic v0, input logic v1, input logic ptr);
        arb_state_e res;
        if (v0 && v1) begin
            res = ptr ? ARB_GNT1 : ARB_GNT0;
        end else if (v0) begin
            res = ARB_GNT0;
        end else if (v1) begin
            res = ARB_GNT1;
        end else begin
            res = ARB_IDLE;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_stream_arbiter_mux.sv
// ============================================================================
// Module   : mux_stream_arbiter_mux
// Brief    : 2:1 data word multiplexer; sel=0 passes in0, sel=1 passes in1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_stream_arbiter_mux #(
    parameter int WIDTH = 16
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

`default_nettype wire

// File: rtl/mux_stream_arbiter.sv
// ============================================================================
// Module   : mux_stream_arbiter
// Brief    : Two-requester round-robin burst arbiter feeding a registered
//            one-entry valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_stream_arbiter
    import mux_stream_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in0_valid,
    input  logic [DATA_BITS-1:0] in0_data,
    output logic                 in0_ready,
    input  logic                 in1_valid,
    input  logic [DATA_BITS-1:0] in1_data,
    output logic                 in1_ready,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_src,
    input  logic                 out_ready,
    output logic                 sel
);

    // CNT_W must be wide enough that BURST_LEN is representable without wrap.
    localparam logic [CNT_W-1:0] c_burst_len = CNT_W'(BURST_LEN);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic                   r_ptr;
    logic                   w_ptr_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_load_en;
    logic                   w_src;
    logic                   w_req;
    logic                   w_beat;
    logic                   w_release;
    logic [DATA_BITS-1:0]   w_mux_data;

    assign w_load_en = !out_valid || out_ready;

    mux_stream_arbiter_mux #(
        .WIDTH (DATA_BITS)
    ) u_mux (
        .sel (sel),
        .in0 (in0_data),
        .in1 (in1_data),
        .out (w_mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        sel         = r_ptr;
        in0_ready   = 1'b0;
        in1_ready   = 1'b0;
        w_src       = 1'b0;
        w_req       = 1'b0;
        w_beat      = 1'b0;
        w_release   = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                w_state_nxt = arb_pick(in0_valid, in1_valid, r_ptr);
            end
            ARB_GNT0, ARB_GNT1: begin
                w_src     = (r_state == ARB_GNT1);
                sel       = w_src;
                w_req     = w_src ? in1_valid : in0_valid;
                in0_ready = !w_src && w_load_en;
                in1_ready =  w_src && w_load_en;
                w_beat    = w_req && w_load_en;
                // A stalled output with the requester idle keeps the grant.
                w_release = (w_beat && ((r_cnt + CNT_W'(1)) == c_burst_len)) ||
                            (!w_req && w_load_en);
                if (w_release) begin
                    w_ptr_nxt   = ~w_src;
                    w_cnt_nxt   = '0;
                    w_state_nxt = arb_pick(in0_valid, in1_valid, ~w_src);
                end else if (w_beat) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (w_beat) begin
            out_valid <= 1'b1;
            out_data  <= w_mux_data;
            out_src   <= w_src;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire
